// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the MEM-stage data-memory access path.
package mem_pkg;
  localparam int STRB_W = 8;
  localparam int OFF_W = 3;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LD = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100, F3_LHU = 3'b101, F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010, F3_SD = 3'b011;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    return sz[1] ? (sz[0] ? 8'hFF : 8'h0F) : (sz[0] ? 8'h03 : 8'h01);
  endfunction
  // offset bits that must be zero for an access of this size to be aligned
  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] sz);
    return 3'b111 >> (2'd3 - sz);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: extract the addressed bytes from a memory word and sign/zero-extend them.
module load_align
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] i_rdata,
  input  logic [OFF_W-1:0]     i_offset,
  input  logic [2:0]           i_funct3,
  output logic [BUS_WIDTH-1:0] o_data
);
  logic [BUS_WIDTH-1:0] w_shift;
  logic                 w_sx;
  logic [1:0]           w_sz;
  assign w_shift = i_rdata >> {i_offset, 3'b000};
  assign w_sx = ~i_funct3[2];
  assign w_sz = i_funct3[1:0];
  always_comb begin
    o_data = w_shift;
    o_data = (w_sz == F3_LB[1:0]) ? {{(BUS_WIDTH-8){w_sx & w_shift[7]}}, w_shift[7:0]} :
             (w_sz == F3_LH[1:0]) ? {{(BUS_WIDTH-16){w_sx & w_shift[15]}}, w_shift[15:0]} :
             (w_sz == F3_LW[1:0]) ? {{(BUS_WIDTH-32){w_sx & w_shift[31]}}, w_shift[31:0]} :
             w_shift;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns EX/MEM load/store control into one outstanding ready/valid
// data-memory request, stalls the pipeline meanwhile and returns aligned load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int STRB_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_mem_read,
  input  logic                   in_mem_write,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [BUS_WIDTH-1:0]   in_addr,
  input  logic [BUS_WIDTH-1:0]   in_store_data,
  output logic                   stall,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_we,
  output logic [BUS_WIDTH-1:0]   req_addr,
  output logic [BUS_WIDTH-1:0]   req_wdata,
  output logic [STRB_WIDTH-1:0]  req_wstrb,
  input  logic                   resp_valid,
  input  logic [BUS_WIDTH-1:0]   resp_rdata,
  input  logic                   resp_err,
  output logic [BUS_WIDTH-1:0]   load_data,
  output logic                   load_valid,
  output logic                   mem_done,
  output logic                   misaligned,
  output logic                   access_fault
);
  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [2:0]           r_funct3;
  logic [OFF_W-1:0]     r_off;
  logic                 r_err;
  logic [BUS_WIDTH-1:0] r_load_data;
  logic [2:0]           w_funct3;
  logic [OFF_W-1:0]     w_off;
  logic                 w_access;
  logic                 w_aligned;
  logic                 w_start;
  logic [BUS_WIDTH-1:0] w_aligned_data;
  logic                 w_unused_instr;
  assign w_funct3 = in_instr[14:12];
  assign w_off = in_addr[OFF_W-1:0];
  assign w_access = in_mem_read | in_mem_write;
  assign w_aligned = (w_off & align_mask(w_funct3[1:0])) == '0;
  assign w_start = (r_state == ST_IDLE) & w_access & w_aligned;
  assign w_unused_instr = ^{in_instr[INSTR_WIDTH-1:15], in_instr[11:0]};
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE) ? (w_start ? ST_REQ : ST_IDLE) :
             (r_state == ST_REQ)  ? (req_ready ? ST_WAIT : ST_REQ) :
             (r_state == ST_WAIT) ? (resp_valid ? ST_DONE : ST_WAIT) :
             ST_IDLE;
  end
  load_align #(.BUS_WIDTH(BUS_WIDTH)) u_load_align (
    .i_rdata  (resp_rdata),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_aligned_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_funct3    <= '0;
      r_off       <= '0;
      r_err       <= 1'b0;
      r_load_data <= '0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wstrb   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_funct3  <= w_funct3;
        r_off     <= w_off;
        req_we    <= in_mem_write;
        req_addr  <= {in_addr[BUS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        req_wdata <= in_store_data << {w_off, 3'b000};
        req_wstrb <= STRB_WIDTH'(size_mask(w_funct3[1:0]) << w_off);
      end
      if (r_state == ST_WAIT && resp_valid) begin
        r_err <= resp_err;
        if (!req_we) r_load_data <= w_aligned_data;
      end
    end
  end
  assign load_data = r_load_data;
  assign req_valid = r_state == ST_REQ;
  // DONE drops stall so the pipeline advances past the completed access
  assign stall = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign mem_done = r_state == ST_DONE;
  assign load_valid = (r_state == ST_DONE) & ~req_we;
  assign access_fault = (r_state == ST_DONE) & r_err;
  assign misaligned = (r_state == ST_IDLE) & w_access & ~w_aligned;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the MEM-stage access unit against hand-computed values.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_mem_read, in_mem_write;
  logic [31:0] in_instr;
  logic [63:0] in_addr, in_store_data;
  logic        stall, req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata, load_data;
  logic        load_valid, mem_done, misaligned, access_fault;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_instr(in_instr), .in_addr(in_addr), .in_store_data(in_store_data), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .load_data(load_data),
    .load_valid(load_valid), .mem_done(mem_done), .misaligned(misaligned),
    .access_fault(access_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_mem_read = 0; in_mem_write = 0; in_instr = 0; in_addr = 0; in_store_data = 0;
    req_ready = 0; resp_valid = 0; resp_err = 0; resp_rdata = 0;
  endtask

  // Drives one access, holding ready/resp low for rdly/vdly cycles; returns on the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input logic err, input int rdly,
                        input int vdly, input logic [63:0] exp_addr,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                        output int n_cyc);
    int rc = 0, vc = 0;
    logic acc = 0;
    n_cyc = 1;
    in_mem_read = rd; in_mem_write = wr; in_instr = {17'b0, f3, 12'b0};
    in_addr = addr; in_store_data = sdata; resp_rdata = rdata; resp_err = err;
    while (!mem_done && n_cyc < 30) begin
      req_ready = 0; resp_valid = 0;
      if (req_valid) begin
        req_ready = rc >= rdly;
        rc++;
        chk("req_addr", req_addr, exp_addr);
        chk("req_we", {63'b0, req_we}, {63'b0, wr});
        if (wr) begin
          chk("req_wdata", req_wdata, exp_wdata);
          chk("req_wstrb", {56'b0, req_wstrb}, {56'b0, exp_wstrb});
        end
        if (req_ready) acc = 1;
      end else if (acc) begin
        resp_valid = vc >= vdly;
        vc++;
      end
      #1;
      chk("stall_busy", {63'b0, stall}, 64'd1);
      tick;
      n_cyc++;
    end
    req_ready = 0; resp_valid = 0;
    chk("done_reached", {63'b0, mem_done}, 64'd1);
  endtask

  initial begin
    rst_n = 0;
    clear_inputs;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {63'b0, req_valid}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_outs", {56'b0, req_we, mem_done, load_valid, misaligned, access_fault, 3'b0}, 64'd0);
    chk("rst_load_data", load_data, 64'd0);
    chk("rst_wstrb", {56'b0, req_wstrb}, 64'd0);
    rst_n = 1;
    tick;

    // SW 0xDEADBEEF at 0x1004
    access(0, 1, 3'b010, 64'h1004, 64'hDEADBEEF, 64'h0, 0, 0, 0,
           64'h1000, 64'hDEADBEEF_00000000, 8'hF0, cyc);
    chk("sw_cycles", 64'(cyc), 64'd4);
    chk("sw_stall_done", {63'b0, stall}, 64'd0);
    chk("sw_load_valid", {63'b0, load_valid}, 64'd0);
    chk("sw_fault", {63'b0, access_fault}, 64'd0);
    clear_inputs;
    tick;
    chk("sw_done_pulse", {63'b0, mem_done}, 64'd0);

    // LB at 0x2003
    access(1, 0, 3'b000, 64'h2003, 64'h0, 64'h00000000_80000000, 0, 0, 0,
           64'h2000, 64'h0, 8'h0, cyc);
    chk("lb_cycles", 64'(cyc), 64'd4);
    chk("lb_load_valid", {63'b0, load_valid}, 64'd1);
    chk("lb_data", load_data, 64'hFFFFFFFF_FFFFFF80);
    clear_inputs;
    tick;
    chk("lb_valid_pulse", {63'b0, load_valid}, 64'd0);

    // LBU at 0x2003
    access(1, 0, 3'b100, 64'h2003, 64'h0, 64'h00000000_80000000, 0, 0, 0,
           64'h2000, 64'h0, 8'h0, cyc);
    chk("lbu_data", load_data, 64'h80);
    clear_inputs;
    tick;

    // LH at 0x2006, sign bit set
    access(1, 0, 3'b001, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 0,
           64'h2000, 64'h0, 8'h0, cyc);
    chk("lh_data", load_data, 64'hFFFFFFFF_FFFF8001);
    clear_inputs;
    tick;

    // LWU at 0x2004
    access(1, 0, 3'b110, 64'h2004, 64'h0, 64'hF0000000_12345678, 0, 0, 0,
           64'h2000, 64'h0, 8'h0, cyc);
    chk("lwu_data", load_data, 64'h00000000_F0000000);
    clear_inputs;
    tick;

    // SB 0xAB at 0x1007 (upper lane)
    access(0, 1, 3'b000, 64'h1007, 64'hAB, 64'h0, 0, 0, 0,
           64'h1000, 64'hAB000000_00000000, 8'h80, cyc);
    chk("sb_done", {63'b0, mem_done}, 64'd1);
    clear_inputs;
    tick;

    // LH at 0x2001 is misaligned
    in_mem_read = 1; in_instr = 32'h0000_1000; in_addr = 64'h2001;
    #1;
    chk("mis_flag", {63'b0, misaligned}, 64'd1);
    chk("mis_stall", {63'b0, stall}, 64'd0);
    chk("mis_req_valid", {63'b0, req_valid}, 64'd0);
    tick;
    clear_inputs;
    #1;
    chk("mis_pulse", {63'b0, misaligned}, 64'd0);
    chk("mis_no_req", {63'b0, req_valid}, 64'd0);
    tick;
    chk("mis_no_req2", {63'b0, req_valid}, 64'd0);

    // LD at 0x3000, ready late 3 cycles, resp late 2 cycles, bus error
    access(1, 0, 3'b011, 64'h3000, 64'h0, 64'h01234567_89ABCDEF, 1, 3, 2,
           64'h3000, 64'h0, 8'h0, cyc);
    chk("ld_cycles", 64'(cyc), 64'd9);
    chk("ld_fault", {63'b0, access_fault}, 64'd1);
    chk("ld_load_valid", {63'b0, load_valid}, 64'd1);
    chk("ld_data", load_data, 64'h01234567_89ABCDEF);
    clear_inputs;
    tick;
    chk("ld_fault_pulse", {63'b0, access_fault}, 64'd0);

    // Stray response while idle
    resp_valid = 1; resp_rdata = 64'h55;
    tick;
    chk("stray_no_done", {63'b0, mem_done}, 64'd0);
    clear_inputs;

    // Reset while waiting for a response
    in_mem_read = 1; in_instr = 32'h0000_2000; in_addr = 64'h4000; req_ready = 1;
    tick;
    chk("rw_req", {63'b0, req_valid}, 64'd1);
    tick;
    chk("rw_wait_stall", {63'b0, stall}, 64'd1);
    chk("rw_wait_noreq", {63'b0, req_valid}, 64'd0);
    in_mem_read = 0; req_ready = 0;
    rst_n = 0;
    #1;
    chk("rw_req_drop", {63'b0, req_valid}, 64'd0);
    chk("rw_stall_drop", {63'b0, stall}, 64'd0);
    tick;
    rst_n = 1;
    resp_valid = 1; resp_rdata = 64'h77;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rw_no_load_valid", {63'b0, load_valid}, 64'd0);
      chk("rw_no_done", {63'b0, mem_done}, 64'd0);
    end
    clear_inputs;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the registered load/store control, address (`alu_fpu_result`), store data (`mem_in`) and `instr` funct3 into a ready/valid request on the data-memory bus, then waits for the response.
- Aligns and sign/zero-extends load data for MEM/WB.
- Drives `stall` to freeze upstream pipeline registers while an access is outstanding.

Parameters:
- BUS_WIDTH, 64, data/address width; fixed 8-byte memory word.
- INSTR_WIDTH, 32, instruction width; funct3 = instr[14:12].
- STRB_WIDTH, 8, byte strobes = BUS_WIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_mem_read  in  1  load in EX/MEM
- in_mem_write  in  1  store in EX/MEM
- in_instr  in  INSTR_WIDTH  instruction (funct3 gives size/sign)
- in_addr  in  BUS_WIDTH  effective address (alu_fpu_result)
- in_store_data  in  BUS_WIDTH  store data (mem_in), LSB-aligned
- stall  out  1  hold EX/MEM and earlier stages
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  BUS_WIDTH  word-aligned address {in_addr[63:3],3'b0}
- req_wdata  out  BUS_WIDTH  store data shifted to byte lane
- req_wstrb  out  STRB_WIDTH  byte enables
- resp_valid  in  1  response/ack valid
- resp_rdata  in  BUS_WIDTH  read word
- resp_err  in  1  bus error with response
- load_data  out  BUS_WIDTH  extended load result
- load_valid  out  1  load_data valid (1-cycle pulse)
- mem_done  out  1  access complete (1-cycle pulse)
- misaligned  out  1  misaligned access fault (1-cycle pulse)
- access_fault  out  1  bus error fault (1-cycle pulse)

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is asynchronous and active-low.
- Reset values:
  - State returns to IDLE.
  - All outputs are 0: `req_valid`, `req_we`, `req_addr`, `req_wdata`, `req_wstrb`, `load_data`, `load_valid`, `mem_done`, `misaligned`, `access_fault`.
  - `stall` is combinational from state and inputs, so it reads 0 in reset.
- Access and size decode:
  - access = in_mem_read | in_mem_write.
  - If both are high, the access is a store.
  - Size from funct3[1:0]: 00=1 B, 01=2 B, 10=4 B, 11=8 B.
  - Loads use funct3[2] as unsigned; 111 is treated as LD.
- Misalignment: in_addr[2:0] not a multiple of size → misaligned pulses for one cycle in IDLE, no bus request is issued, stall stays 0.
- Store lanes:
  - req_wstrb = size mask << in_addr[2:0].
  - req_wdata = in_store_data << (8*in_addr[2:0]).
- Load extraction: resp_rdata >> (8*offset), then truncate to size and sign- or zero-extend to BUS_WIDTH.
- FSM states:
  - IDLE: on an aligned access, latch addr/we/wdata/wstrb/funct3/offset and go to REQ. stall=1 this cycle.
  - REQ: req_valid=1; address, we, wdata and wstrb are held stable. If req_ready, go to WAIT. stall=1.
  - WAIT: req_valid=0. If resp_valid, register load_data, capture resp_err and go to DONE. stall=1.
  - DONE: mem_done=1; load_valid=1 for loads; access_fault=resp_err. stall=0 so the pipeline advances. Next state is IDLE.
- Latency: minimum 4 cycles from access visible to DONE (IDLE, REQ with ready, WAIT with resp, DONE). Each cycle of req_ready=0 or resp_valid=0 adds one.
- IDLE after DONE: the next instruction is sampled in IDLE. Back-to-back accesses therefore cost 4 cycles each.
- Stray responses: resp_valid outside WAIT is ignored.
- Reset mid-operation: asynchronous return to IDLE. req_valid drops immediately. Any late response is ignored.
- Only one request is outstanding at a time; there is no pipelining of requests.

Decomposition:
- Shared package mem_pkg:
  - funct3 encodings (LB..LWU, SB..SD).
  - FSM state encoding (IDLE, REQ, WAIT, DONE).
  - STRB_WIDTH and offset width constant (3).
- One sub-module, load_align: purely combinational extract + sign/zero extend from (rdata, offset, funct3). Reusable by a future cache.

Test Plan:
- SW at 0x1004, data 0xDEADBEEF, req_ready=1, resp next cycle:
  - req_addr=0x1000, req_wstrb=0xF0, req_wdata=0xDEADBEEF_00000000, req_we=1.
  - stall high for 3 cycles, mem_done in cycle 4.
- LB at 0x2003, resp_rdata=0x00000000_80000000 → load_data=0xFFFFFFFF_FFFFFF80, load_valid pulse.
- LBU at the same address → load_data=0x80.
- LH at 0x2001 → misaligned=1 for one cycle, req_valid never asserts, stall=0.
- LD at 0x3000 with req_ready low 3 cycles and resp_valid delayed 2 cycles:
  - req_valid and req_addr stable throughout.
  - stall held; done on cycle 9.
  - resp_err=1 → access_fault pulse with mem_done.
- Assert rst_n low while in WAIT:
  - State=IDLE and req_valid=0 immediately.
  - A subsequent resp_valid produces no load_valid.
